// File: rtl/gf_div_unit_if.sv
// Request/response bundle for the GF(2^m) divider: operands and start in, status and quotient out.
// Carries no state; timing is set entirely by gf_div_unit.
// No backpressure: start is a pulse that the divider takes only when idle.
// Signals: start, dividend, divisor (requester -> divider); busy, done, result, div_zero (divider -> requester).
// All vectors use [0:m-1] order, index 0 holding the x^(m-1) coefficient.
interface gf_div_unit_if #(
  parameter int m = 16
);
  logic         start;
  logic [0:m-1] dividend;
  logic [0:m-1] divisor;
  logic         busy;
  logic         done;
  logic [0:m-1] result;
  logic         div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, result, div_zero
  );
endinterface

// File: rtl/gf_div_unit.sv
// Computes a * b^-1 in GF(2^m) mod POLY with a binary extended Euclid, one step per cycle, no multiplier.
// Latency: fixed 2m+2 cycles from start acceptance to the done pulse, independent of operand values.
// Backpressure: start is taken only in IDLE with no done pending; starts while busy are dropped, not queued.
// Ports: clk, rst_n (synchronous, active-low); div_if (slave): start/dividend/divisor in,
//        busy/done/result/div_zero out. result and div_zero hold from one done to the next.
module gf_div_unit #(
  parameter int         m    = 16,
  parameter logic [m:0] POLY = 17'h1002D
) (
  input  logic         clk,
  input  logic         rst_n,
  gf_div_unit_if.slave div_if
);

  localparam int CW = $clog2(2 * m);
  // delta spans roughly -(2m+1) .. m over the run
  localparam int DW = $clog2(2 * m + 2) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIN} state_t;

  state_t         state_q, state_d;
  logic [m-1:0]   a_q, a_d, b_q, b_d;
  logic [m:0]     r_q, r_d, s_q, s_d;
  logic [m-1:0]   u_q, u_d, v_q, v_d;
  logic [DW-1:0]  delta_q, delta_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [m-1:0]   res_q, res_d;
  logic           dz_q, dz_d;
  logic           done_q, done_d;

  // Multiply by x^-1 modulo POLY. POLY has a constant term, so adding it
  // to an odd value makes it divisible by x and the shift is exact.
  function automatic logic [m-1:0] div_x(input logic [m-1:0] t);
    logic [m:0] e;
    e = {1'b0, t} ^ (t[0] ? POLY : '0);
    return e[m:1];
  endfunction

  // Invariants kept every step (mod POLY): r*a == u*b and s*a == v*b.
  // r is always odd; delta = bound(deg s) - bound(deg r), and the sum of the
  // two degree bounds drops by one per step, so after 2m steps s == 0, which
  // forces r == gcd == 1 and hence u == a/b. Once s == 0, v is 0 as well, so
  // the remaining steps leave u and v untouched.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    u_d     = u_q;
    v_d     = v_q;
    delta_d = delta_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // the done cycle is still part of the operation, so no start then
        if (div_if.start && !done_q) begin
          a_d     = div_if.dividend;
          b_d     = div_if.divisor;
          state_d = LOAD;
        end
      end

      LOAD: begin
        r_d     = POLY;
        s_d     = {1'b0, b_q};
        u_d     = '0;
        v_d     = a_q;
        delta_d = '1;
        cnt_d   = '0;
        state_d = ITER;
      end

      ITER: begin
        if (!s_q[0]) begin
          s_d     = s_q >> 1;
          v_d     = div_x(v_q);
          delta_d = delta_q - DW'(1);
        end else if (delta_q[DW-1]) begin
          // s has the smaller degree bound: it becomes the new r, and the
          // old r is folded into the new s. ~delta == -delta-1.
          r_d     = s_q;
          u_d     = v_q;
          s_d     = (s_q ^ r_q) >> 1;
          v_d     = div_x(v_q ^ u_q);
          delta_d = ~delta_q;
        end else begin
          s_d     = (s_q ^ r_q) >> 1;
          v_d     = div_x(v_q ^ u_q);
          delta_d = delta_q - DW'(1);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * m - 1)) begin
          state_d = FIN;
        end
      end

      FIN: begin
        dz_d    = (b_q == '0);
        res_d   = (b_q == '0) ? '0 : u_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      delta_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      u_q     <= u_d;
      v_q     <= v_d;
      delta_q <= delta_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign div_if.busy     = (state_q != IDLE) || done_q;
  assign div_if.done     = done_q;
  assign div_if.result   = res_q;
  assign div_if.div_zero = dz_q;

endmodule

// File: tb/tb_gf_div_unit.sv
// Bench for gf_div_unit (m=16): directed operand pairs with known quotients plus a
// batch of random pairs checked by multiplying back; a monitor pops expectations on done.
// Also exercises ignored starts, start on the done cycle, and reset aborts.
`timescale 1ns/1ps
module tb_gf_div_unit;
  localparam int M   = 16;
  localparam int LAT = 2 * M + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gf_div_unit_if #(.m(M)) div_if ();

  gf_div_unit #(.m(M), .POLY(17'h1002D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (div_if)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        dz;
    bit          model;
    int          start_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference multiply in GF(2^16) mod x^16+x^5+x^3+x^2+1
  function automatic logic [15:0] gf_mul(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] acc;
    acc = '0;
    for (int i = 15; i >= 0; i--) begin
      acc = acc << 1;
      if (acc[16]) acc = acc ^ 17'h1002D;
      if (y[i]) acc = acc ^ {1'b0, x};
    end
    return acc[15:0];
  endfunction

  // Monitor: every done must match the oldest outstanding request.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (div_if.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("done_without_request", div_if.done, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("latency", cyc - e.start_cyc, LAT);
          check("busy_on_done", div_if.busy, 1'b1);
          if (e.model) begin
            check("mul_back", gf_mul(div_if.result, e.b), e.a);
            check("div_zero", div_if.div_zero, 1'b0);
          end else begin
            check("result", div_if.result, e.res);
            check("div_zero", div_if.div_zero, e.dz);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Called at #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                       input logic dz, input bit model);
    exp_t e;
    div_if.start    = 1'b1;
    div_if.dividend = a;
    div_if.divisor  = b;
    @(posedge clk);
    #1;
    e.a = a; e.b = b; e.res = r; e.dz = dz; e.model = model; e.start_cyc = cyc;
    sb_q.push_back(e);
    div_if.start    = 1'b0;
    // operands change after capture; they must not matter
    div_if.dividend = ~a;
    div_if.divisor  = b ^ 16'h5A5A;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || div_if.busy !== 1'b0) && k < 4 * LAT) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_pending", sb_q.size(), 0);
    check("done_low_after", div_if.done, 1'b0);
    sb_q.delete();
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input logic dz, input bit model);
    issue(a, b, r, dz, model);
    wait_drain();
  endtask

  initial begin : stim
    logic [15:0] ra, rb;
    exp_t e2;

    // reset with start asserted: must be ignored
    rst_n           = 1'b0;
    div_if.start    = 1'b1;
    div_if.dividend = 16'h1111;
    div_if.divisor  = 16'h2222;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", div_if.busy, 1'b0);
    check("rst_done", div_if.done, 1'b0);
    check("rst_result", div_if.result, 16'h0000);
    check("rst_div_zero", div_if.div_zero, 1'b0);
    rst_n        = 1'b1;
    div_if.start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_rst", div_if.busy, 1'b0);

    // 1/x
    issue(16'h0001, 16'h0002, 16'h8016, 1'b0, 1'b0);
    check("busy_after_accept", div_if.busy, 1'b1);
    wait_drain();

    run_op(16'h0003, 16'h0003, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_op(16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h2468, 16'h0002, 16'h1234, 1'b0, 1'b0);
    run_op(16'h0006, 16'h0003, 16'h0002, 1'b0, 1'b0);
    run_op(16'h002D, 16'h8000, 16'h0002, 1'b0, 1'b0);  // x^16 / x^15
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hABCD, 16'h0001, 16'hABCD, 1'b0, 1'b0);

    // starts during the operation and on the done cycle are dropped;
    // a start held into the following cycle launches the next operation
    issue(16'h0006, 16'h0003, 16'h0002, 1'b0, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      if (k == 4 || k == 32) begin
        div_if.start    = 1'b1;
        div_if.dividend = 16'hFFFF;
        div_if.divisor  = 16'h0001;
      end
      if (k == 5 || k == 33) div_if.start = 1'b0;
      if (k == 20) check("result_hold", div_if.result, 16'hABCD);
      if (k == 34) begin
        div_if.start    = 1'b1;
        div_if.dividend = 16'h0001;
        div_if.divisor  = 16'h0002;
        e2.a = 16'h0001; e2.b = 16'h0002; e2.res = 16'h8016; e2.dz = 1'b0;
        e2.model = 1'b0; e2.start_cyc = cyc + 2;
        sb_q.push_back(e2);
      end
      if (k == 35) check("start_on_done_ignored", div_if.busy, 1'b0);
      if (k == 36) begin
        check("start_after_done_taken", div_if.busy, 1'b1);
        div_if.start    = 1'b0;
        div_if.dividend = 16'h7777;
        div_if.divisor  = 16'h0000;
      end
    end
    wait_drain();

    // reset in the middle of an operation aborts it with no done
    issue(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) begin
        sb_q.delete();
        rst_n        = 1'b0;
        div_if.start = 1'b1;
      end
      if (k == 10) begin
        check("abort_busy", div_if.busy, 1'b0);
        check("abort_done", div_if.done, 1'b0);
        check("abort_result", div_if.result, 16'h0000);
        check("abort_div_zero", div_if.div_zero, 1'b0);
      end
      if (k == 12) begin
        rst_n        = 1'b1;
        div_if.start = 1'b0;
      end
      if (k == 13) check("idle_after_abort", div_if.busy, 1'b0);
    end
    run_op(16'h2468, 16'h0002, 16'h1234, 1'b0, 1'b0);

    // reset while idle clears a latched div_zero
    run_op(16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_clears_div_zero", div_if.div_zero, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random nonzero divisors, checked by multiplying the quotient back
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rb == 16'h0000) rb = 16'h0001;
      run_op(ra, rb, 16'h0000, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
